// File: rtl/mem_responder_pkg.sv
// Shared encodings for the memory responder: funct3 access codes and FSM states.
package mem_responder_pkg;

  localparam int unsigned CNT_W = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Legal funct3/direction combinations; unsigned loads have no store form.
  function automatic logic f3_legal(input logic [2:0] f3, input logic we);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: load extraction/extension, store merging, misalignment detection.
module mem_lane_align
  import mem_responder_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rword_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_word_o,
  output logic        misalign_o
);

  logic [4:0]  sh;
  logic [31:0] shifted;
  logic [31:0] lane_mask;

  assign sh      = {addr_lo_i, 3'b000};
  assign shifted = rword_i >> sh;

  // Select lanes by size, extend loads, and merge store data into the old word.
  always_comb begin
    load_data_o  = '0;
    store_word_o = rword_i;
    misalign_o   = 1'b0;
    lane_mask    = '0;
    case (funct3_i)
      F3_B: begin
        load_data_o  = {{24{shifted[7]}}, shifted[7:0]};
        lane_mask    = 32'h0000_00FF << sh;
        store_word_o = (rword_i & ~lane_mask) | ((32'(wdata_i[7:0]) << sh) & lane_mask);
      end
      F3_BU: begin
        load_data_o = {24'd0, shifted[7:0]};
      end
      F3_H: begin
        misalign_o   = addr_lo_i[0];
        load_data_o  = {{16{shifted[15]}}, shifted[15:0]};
        lane_mask    = 32'h0000_FFFF << sh;
        store_word_o = (rword_i & ~lane_mask) | ((32'(wdata_i[15:0]) << sh) & lane_mask);
      end
      F3_HU: begin
        misalign_o  = addr_lo_i[0];
        load_data_o = {16'd0, shifted[15:0]};
      end
      F3_W: begin
        misalign_o   = (addr_lo_i != 2'b00);
        load_data_o  = shifted;
        store_word_o = wdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with fixed access latency and registered response.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0] ram_q [DEPTH];

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [AW-1:0]     widx;
  logic [31:0]       rword;
  logic [31:0]       load_data;
  logic [31:0]       store_word;
  logic              misalign;
  logic              err_c;
  logic              ram_we_c;

  assign widx  = addr_q[AW+1:2];
  assign rword = ram_q[widx];
  assign err_c = (addr_q >= 32'(DEPTH * 4)) | ~f3_legal(f3_q, we_q) | misalign;

  mem_lane_align u_align (
    .funct3_i     (f3_q),
    .addr_lo_i    (addr_q[1:0]),
    .rword_i      (rword),
    .wdata_i      (wdata_q),
    .load_data_o  (load_data),
    .store_word_o (store_word),
    .misalign_o   (misalign)
  );

  // State, counter, capture and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      f3_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next-state and next-output logic; the access happens on the edge leaving BUSY.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    f3_d        = f3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    ram_we_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          we_d        = req_we;
          f3_d        = req_funct3;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          cnt_d       = CNT_W'(LATENCY - 1);
          req_ready_d = 1'b0;
          state_d     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = err_c;
          rsp_rdata_d = '0;
          if (!err_c) begin
            if (we_q) ram_we_c = 1'b1;
            else      rsp_rdata_d = load_data;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Storage write; a same-edge reset cancels the commit.
  always_ff @(posedge clk) begin
    if (!reset && ram_we_c) ram_q[widx] <= store_word;
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with an expected-response queue.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we, rsp_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        req_valid2, req_we2, rsp_ready2;
  logic [2:0]  req_funct32;
  logic [31:0] req_addr2, req_wdata2;
  logic        req_ready2, rsp_valid2, rsp_err2;
  logic [31:0] rsp_rdata2;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH(1024), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  mem_responder #(.DEPTH(1024), .LATENCY(1)) dut2 (
    .clk(clk), .reset(reset), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_we(req_we2), .req_funct3(req_funct32), .req_addr(req_addr2), .req_wdata(req_wdata2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one request for one accept edge and queue its expected response.
  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] exp_rdata, input logic exp_err);
    exp_t e;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    sb_q.push_back(e);
  endtask

  // Wait (bounded) for rsp_valid, check latency and compare against the queue head.
  task automatic wait_rsp(input string tag);
    int   n = 0;
    exp_t e;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      n++;
      if (rsp_valid === 1'b1) break;
    end
    check({tag, "_latency"}, 32'(n), 32'd2);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_rdata"}, rsp_rdata, e.rdata);
      check({tag, "_err"}, 32'(rsp_err), 32'(e.err));
    end
  endtask

  task automatic finish_rsp(input string tag);
    @(posedge clk); #1;
    check({tag, "_rsp_valid_low"}, 32'(rsp_valid), 32'd0);
    check({tag, "_req_ready_back"}, 32'(req_ready), 32'd1);
  endtask

  task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] exp_rdata, input logic exp_err);
    send(we, f3, addr, wd, exp_rdata, exp_err);
    wait_rsp(tag);
    finish_rsp(tag);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b010;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    req_valid2 = 1'b0; req_we2 = 1'b0; req_funct32 = 3'b010;
    req_addr2 = '0; req_wdata2 = '0; rsp_ready2 = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);

    // Basic word store/load and sub-word accesses
    txn("sw10",  1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    txn("lw10",  1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    txn("sb13",  1'b1, 3'b000, 32'h13, 32'h00000080, 32'h0, 1'b0);
    txn("lb13",  1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0);
    txn("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h00000080, 1'b0);
    txn("lw10b", 1'b0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0);
    txn("lh12",  1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF80AD, 1'b0);
    txn("lhu10", 1'b0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 1'b0);
    txn("sh12",  1'b1, 3'b001, 32'h12, 32'hFFFF1234, 32'h0, 1'b0);
    txn("lw10c", 1'b0, 3'b010, 32'h10, 32'h0, 32'h1234BEEF, 1'b0);

    // Error cases: no side effects
    txn("lh11_mis",  1'b0, 3'b001, 32'h11, 32'h0, 32'h0, 1'b1);
    txn("lw1000",    1'b0, 3'b010, 32'h1000, 32'h0, 32'h0, 1'b1);
    txn("sw12_mis",  1'b1, 3'b010, 32'h12, 32'hFFFFFFFF, 32'h0, 1'b1);
    txn("sbu_st",    1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1);
    txn("f3_011",    1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
    txn("lw10_keep", 1'b0, 3'b010, 32'h10, 32'h0, 32'h1234BEEF, 1'b0);

    // Backpressure: response must hold while rsp_ready is low
    rsp_ready = 1'b0;
    send(1'b0, 3'b010, 32'h10, 32'h0, 32'h1234BEEF, 1'b0);
    wait_rsp("hold");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_rdata", rsp_rdata, 32'h1234BEEF);
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    finish_rsp("hold");

    // Reset on the commit edge cancels the store
    txn("sw20_old", 1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0);
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h12345678;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rstc_req_ready", 32'(req_ready), 32'd1);
    check("rstc_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstc_rdata", rsp_rdata, 32'd0);
    check("rstc_err", 32'(rsp_err), 32'd0);
    txn("lw20_old", 1'b0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0);

    // LATENCY=1 instance: seed a word, then stream loads with rsp_ready high
    req_we2 = 1'b1; req_funct32 = 3'b010; req_addr2 = 32'h4; req_wdata2 = 32'hA5A50001;
    req_valid2 = 1'b1;
    @(posedge clk); #1;
    req_valid2 = 1'b0;
    @(posedge clk); #1;
    check("l1_store_rsp", 32'(rsp_valid2), 32'd1);
    @(posedge clk); #1;
    check("l1_idle_ready", 32'(req_ready2), 32'd1);
    req_we2 = 1'b0; req_valid2 = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      check("l1_rsp_valid", 32'(rsp_valid2), 32'((c % 3) == 2));
      check("l1_req_ready", 32'(req_ready2), 32'((c % 3) == 0));
      if ((c % 3) == 2) check("l1_rdata", rsp_rdata2, 32'hA5A50001);
    end
    req_valid2 = 1'b0;

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
